// File: rtl/msrv32_wb_write_queue.sv
// -----------------------------------------------------------------------------
// msrv32_wb_write_queue
//
// Write-back queue between the write-back mux and the integer register file.
// Results are buffered in a small in-order FIFO, and at most one buffered write
// is drained per cycle onto the register file write port. Decode reads the
// per-operand busy flags to stall until an outstanding write has landed.
//
// Ports:
//   clk_in          clock; all state updates on the rising edge
//   reset_in        asynchronous, active-high reset
//   flush_in        synchronous flush of all queued and in-flight writes
//   req_valid_in    producer offers a write
//   req_addr_in     destination register index
//   req_data_in     destination value
//   req_ready_out   queue can accept (combinational, not full)
//   wr_en_out       register file write enable (registered)
//   rd_addr_out     register file write index (registered)
//   rd_out          register file write data (registered)
//   rs_1_addr_in    decode source operand 1 index
//   rs_2_addr_in    decode source operand 2 index
//   rs_1_busy_out   a pending write targets rs_1_addr_in
//   rs_2_busy_out   a pending write targets rs_2_addr_in
//   count_out       number of entries currently held in the FIFO
// -----------------------------------------------------------------------------
module msrv32_wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             req_valid_in,
  input  logic [4:0]       req_addr_in,
  input  logic [31:0]      req_data_in,
  output logic             req_ready_out,
  output logic             wr_en_out,
  output logic [4:0]       rd_addr_out,
  output logic [31:0]      rd_out,
  input  logic [4:0]       rs_1_addr_in,
  input  logic [4:0]       rs_2_addr_in,
  output logic             rs_1_busy_out,
  output logic             rs_2_busy_out,
  output logic [PTR_W:0]   count_out
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]       addr_q  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic handshake;
  logic push;
  logic pop;

  // Ready is not relaxed by a same-cycle pop: a full queue always stalls.
  assign req_ready_out = (count_q != FULL_COUNT);
  assign handshake     = req_valid_in && req_ready_out;

  // Writes to x0 are acknowledged but never stored.
  assign push = handshake && (req_addr_in != 5'd0) && !flush_in;
  assign pop  = (count_q != '0) && !flush_in;

  assign count_out = count_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      wr_en_out   <= 1'b0;
      rd_addr_out <= 5'd0;
      rd_out      <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else if (flush_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      wr_en_out <= 1'b0;
    end else begin
      if (pop) begin
        wr_en_out         <= 1'b1;
        rd_addr_out       <= addr_q[rd_ptr_q];
        rd_out            <= data_q[rd_ptr_q];
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end else begin
        wr_en_out <= 1'b0;
      end

      // A push never lands on the slot being popped unless the queue is
      // full, and a full queue never pushes, so this valid set cannot
      // collide with the pop clear above.
      if (push) begin
        addr_q[wr_ptr_q]  <= req_addr_in;
        data_q[wr_ptr_q]  <= req_data_in;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A write stays visible as busy until the cycle its wr_en_out pulse ends,
  // i.e. until the register file has actually captured it.
  always_comb begin
    rs_1_busy_out = 1'b0;
    rs_2_busy_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == rs_1_addr_in)) rs_1_busy_out = 1'b1;
      if (valid_q[i] && (addr_q[i] == rs_2_addr_in)) rs_2_busy_out = 1'b1;
    end
    if (wr_en_out && (rd_addr_out == rs_1_addr_in)) rs_1_busy_out = 1'b1;
    if (wr_en_out && (rd_addr_out == rs_2_addr_in)) rs_2_busy_out = 1'b1;
    if (rs_1_addr_in == 5'd0) rs_1_busy_out = 1'b0;
    if (rs_2_addr_in == 5'd0) rs_2_busy_out = 1'b0;
  end

endmodule

// File: tb/tb_msrv32_wb_write_queue.sv
module tb_msrv32_wb_write_queue;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic [4:0]  req_addr_in = 5'd0;
  logic [31:0] req_data_in = 32'd0;
  logic        req_ready_out;
  logic        wr_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic [4:0]  rs_1_addr_in = 5'd0;
  logic [4:0]  rs_2_addr_in = 5'd0;
  logic        rs_1_busy_out;
  logic        rs_2_busy_out;
  logic [2:0]  count_out;

  int tests_run = 0;
  int tests_failed = 0;

  msrv32_wb_write_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .flush_in      (flush_in),
    .req_valid_in  (req_valid_in),
    .req_addr_in   (req_addr_in),
    .req_data_in   (req_data_in),
    .req_ready_out (req_ready_out),
    .wr_en_out     (wr_en_out),
    .rd_addr_out   (rd_addr_out),
    .rd_out        (rd_out),
    .rs_1_addr_in  (rs_1_addr_in),
    .rs_2_addr_in  (rs_2_addr_in),
    .rs_1_busy_out (rs_1_busy_out),
    .rs_2_busy_out (rs_2_busy_out),
    .count_out     (count_out)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    step();
    step();
    tests_run++;
    if (count_out !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d expected 0", count_out);
    end
    tests_run++;
    if (wr_en_out !== 1'b0 || rd_addr_out !== 5'd0 || rd_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h expected 0/0/0",
               wr_en_out, rd_addr_out, rd_out);
    end
    reset_in = 1'b0;
    #1;
    tests_run++;
    if (req_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 1", req_ready_out);
    end
  endtask

  task automatic test_single();
    rs_1_addr_in = 5'd5;
    req_valid_in = 1'b1;
    req_addr_in  = 5'd5;
    req_data_in  = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (rs_1_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_pre: got %b expected 0", rs_1_busy_out);
    end
    step();
    req_valid_in = 1'b0;
    #1;
    tests_run++;
    if (count_out !== 3'd1 || wr_en_out !== 1'b0 || rs_1_busy_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_queued: got count=%0d wr_en=%b busy=%b expected 1/0/1",
               count_out, wr_en_out, rs_1_busy_out);
    end
    step();
    tests_run++;
    if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd5 || rd_out !== 32'hDEADBEEF ||
        count_out !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_write: got wr_en=%b addr=%0d data=%h count=%0d expected 1/5/deadbeef/0",
               wr_en_out, rd_addr_out, rd_out, count_out);
    end
    step();
    tests_run++;
    if (wr_en_out !== 1'b0 || rd_addr_out !== 5'd5 || rd_out !== 32'hDEADBEEF ||
        rs_1_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: got wr_en=%b addr=%0d data=%h busy=%b expected 0/5/deadbeef/0",
               wr_en_out, rd_addr_out, rd_out, rs_1_busy_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) begin
      req_valid_in = 1'b1;
      req_addr_in  = 5'(i);
      req_data_in  = 32'h100 + 32'(i);
      #1;
      tests_run++;
      if (req_ready_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready_out);
      end
      step();
      tests_run++;
      if (count_out !== 3'd1) begin
        tests_failed++;
        $display("FAIL b2b_count[%0d]: got %0d expected 1", i, count_out);
      end
      if (i > 1) begin
        tests_run++;
        if (wr_en_out !== 1'b1 || rd_addr_out !== 5'(i - 1) ||
            rd_out !== 32'h100 + 32'(i - 1)) begin
          tests_failed++;
          $display("FAIL b2b_out[%0d]: got wr_en=%b addr=%0d data=%h expected 1/%0d/%h",
                   i, wr_en_out, rd_addr_out, rd_out, i - 1, 32'h100 + 32'(i - 1));
        end
      end
    end
    req_valid_in = 1'b0;
    step();
    tests_run++;
    if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd6 || rd_out !== 32'h106 ||
        count_out !== 3'd0) begin
      tests_failed++;
      $display("FAIL b2b_last: got wr_en=%b addr=%0d data=%h count=%0d expected 1/6/106/0",
               wr_en_out, rd_addr_out, rd_out, count_out);
    end
    step();
  endtask

  task automatic test_x0();
    rs_1_addr_in = 5'd0;
    req_valid_in = 1'b1;
    req_addr_in  = 5'd0;
    req_data_in  = 32'h1234;
    #1;
    tests_run++;
    if (req_ready_out !== 1'b1 || rs_1_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_accept: got ready=%b busy=%b expected 1/0", req_ready_out, rs_1_busy_out);
    end
    step();
    req_valid_in = 1'b0;
    #1;
    tests_run++;
    if (count_out !== 3'd0 || wr_en_out !== 1'b0 || rs_1_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_dropped: got count=%0d wr_en=%b busy=%b expected 0/0/0",
               count_out, wr_en_out, rs_1_busy_out);
    end
    step();
    tests_run++;
    if (wr_en_out !== 1'b0 || rd_out !== 32'h106) begin
      tests_failed++;
      $display("FAIL x0_no_write: got wr_en=%b data=%h expected 0/106", wr_en_out, rd_out);
    end
  endtask

  task automatic test_same_reg();
    logic [2:0]  exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_wr   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_data [4] = '{32'h106, 32'hA, 32'hB, 32'hB};
    rs_1_addr_in = 5'd7;
    rs_2_addr_in = 5'd8;
    req_valid_in = 1'b1;
    req_addr_in  = 5'd7;
    req_data_in  = 32'hA;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) req_data_in = 32'hB;
      if (c == 1) req_valid_in = 1'b0;
      #1;
      tests_run++;
      if (rs_1_busy_out !== exp_busy[c][0] || wr_en_out !== exp_wr[c] ||
          rd_out !== exp_data[c] || rs_2_busy_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL same_reg[%0d]: got busy1=%b busy2=%b wr_en=%b data=%h expected %b/0/%b/%h",
                 c, rs_1_busy_out, rs_2_busy_out, wr_en_out, rd_out,
                 exp_busy[c][0], exp_wr[c], exp_data[c]);
      end
    end
  endtask

  task automatic test_flush();
    rs_1_addr_in = 5'd3;
    rs_2_addr_in = 5'd4;
    req_valid_in = 1'b1;
    req_addr_in  = 5'd3;
    req_data_in  = 32'hC;
    step();
    req_addr_in  = 5'd4;
    req_data_in  = 32'hD;
    flush_in     = 1'b1;
    #1;
    tests_run++;
    if (count_out !== 3'd1 || rs_1_busy_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_pre: got count=%0d busy1=%b expected 1/1", count_out, rs_1_busy_out);
    end
    step();
    flush_in     = 1'b0;
    req_valid_in = 1'b0;
    #1;
    tests_run++;
    if (count_out !== 3'd0 || wr_en_out !== 1'b0 ||
        rs_1_busy_out !== 1'b0 || rs_2_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear: got count=%0d wr_en=%b busy1=%b busy2=%b expected 0/0/0/0",
               count_out, wr_en_out, rs_1_busy_out, rs_2_busy_out);
    end
    step();
    tests_run++;
    if (wr_en_out !== 1'b0 || count_out !== 3'd0) begin
      tests_failed++;
      $display("FAIL flush_drop: got wr_en=%b count=%0d expected 0/0", wr_en_out, count_out);
    end
  endtask

  task automatic test_async_reset();
    req_valid_in = 1'b1;
    req_addr_in  = 5'd9;
    req_data_in  = 32'h99;
    step();
    req_addr_in  = 5'd10;
    req_data_in  = 32'h1010;
    step();
    req_valid_in = 1'b0;
    tests_run++;
    if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd9 || count_out !== 3'd1) begin
      tests_failed++;
      $display("FAIL areset_pre: got wr_en=%b addr=%0d count=%0d expected 1/9/1",
               wr_en_out, rd_addr_out, count_out);
    end
    #2;
    reset_in = 1'b1;
    #1;
    tests_run++;
    if (wr_en_out !== 1'b0 || rd_addr_out !== 5'd0 || rd_out !== 32'd0 ||
        count_out !== 3'd0) begin
      tests_failed++;
      $display("FAIL areset_clear: got wr_en=%b addr=%0d data=%h count=%0d expected 0/0/0/0",
               wr_en_out, rd_addr_out, rd_out, count_out);
    end
    step();
    reset_in = 1'b0;
    step();
    tests_run++;
    if (wr_en_out !== 1'b0 || req_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_after: got wr_en=%b ready=%b expected 0/1", wr_en_out, req_ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_x0();
    test_same_reg();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
